imm_compress: RTL and testbench
===============================

// Module: imm_compress
// PURPOSE
//  Inverse of the immediate extender: takes a 32-bit value and an EOp code, checks if it is
//  exactly representable as a 16-bit immediate under that EOp, and emits the imm16.
//  Streaming valid/ready block with a 2-entry output buffer and saturating statistics counters.
//  Sits between the constant generator and the instruction encoder in the assembler datapath.
// PARAMETERS
//  CNT_W   16  width of the in_cnt / miss_cnt statistics counters
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  in_valid   in   1   in_data/in_eop valid
//  in_ready   out  1   block can accept; a transfer happens when in_valid & in_ready
//  in_data    in   32  value to compress
//  in_eop     in   2   requested encoding: 00 sign, 01 zero, 10 upper (lui), 11 sign<<2
//  out_valid  out  1   out_* hold a result
//  out_ready  in   1   consumer accepts; a transfer happens when out_valid & out_ready
//  out_imm    out  16  encoded immediate
//  out_eop    out  2   encoding actually used
//  out_fit    out  1   1 = ext(out_imm,out_eop) == in_data exactly
//  stat_clr   in   1   synchronous clear of both counters
//  in_cnt     out  CNT_W  accepted inputs, saturating at all-ones
//  miss_cnt   out  CNT_W  accepted inputs with fit=0, saturating
// BEHAVIOUR
//  - Reset (reset_n=0, async): buffer empty, out_valid=0, out_imm=0, out_eop=0, out_fit=0,
//    in_cnt=0, miss_cnt=0; in_ready=1 once reset is released. In-flight data is discarded.
//  - Fit and imm rules per EOp:
//    00: fit = data[31:15] all equal;                     imm = data[15:0]
//    01: fit = data[31:16]==0;                            imm = data[15:0]
//    10: fit = data[15:0]==0;                             imm = data[31:16]
//    11: fit = data[1:0]==0 and data[31:17] all equal;    imm = data[17:2]
//    If fit=0, imm is still computed as above (truncation); no exception is raised.
//  - Latency: registered; result is visible on out_* the cycle after acceptance if the buffer was empty.
//  - Buffer: 2-entry FIFO, states EMPTY / ONE / FULL. in_ready = (state != FULL), registered,
//    with no combinational path from out_ready. Output order equals input order.
//    EMPTY: accept -> ONE.
//    ONE: accept with no pop -> FULL; pop with no accept -> EMPTY; accept and pop -> stays ONE.
//    FULL: pop -> ONE. An accept is impossible in FULL because in_ready=0.
//  - out_* are stable while out_valid=1 and out_ready=0.
//  - Counters update on acceptance: in_cnt += 1, and miss_cnt += 1 if fit=0. Both saturate at 2^CNT_W-1.
//    stat_clr takes priority over a same-cycle increment, so the counters read 0 the next cycle.
// CONFIGURATION
//  - AUTO_SEL_EN defined: in_eop is ignored. The block uses the first fitting encoding in the
//    order 00, 01, 10, 11 and reports it on out_eop. If none fits: out_fit=0, out_eop=00,
//    out_imm=data[15:0].
//  - AUTO_SEL_EN undefined: out_eop = accepted in_eop, and fit is evaluated only for that code.
// TESTING
//  1. Input 32'hFFFF8006, eop 00 -> imm 16'h8006, fit=1. Input 32'h00008006, eop 00 -> fit=0.
//  2. Input 32'h00008006, eop 01 -> imm 16'h8006, fit=1. Input 32'h80060000, eop 10 -> imm 16'h8006, fit=1.
//     Input 32'hFFFE0018, eop 11 -> imm 16'h8006, fit=1. Input 32'h00000019, eop 11 -> fit=0.
//  3. Backpressure: out_ready=0 with 3 inputs offered back-to-back -> 2 accepted, in_ready=0,
//    out_* stable. Then out_ready=1 -> all 3 results emitted in order, none dropped or duplicated.
//  4. Stats: 5 inputs with 2 misses -> in_cnt=5, miss_cnt=2. stat_clr on the same cycle as an accept
//    -> both counters 0. CNT_W=4 with 20 inputs -> in_cnt saturates at 15.
//  5. reset_n pulsed low while FULL -> out_valid=0 immediately and counters 0; after release,
//    in_ready=1 and the first new input is output first.
//  6. AUTO_SEL_EN: 32'h00008006 -> eop 01, fit=1. 32'h80060000 -> eop 10.
//    32'h12345678 -> fit=0, eop 00.

Source files
------------

// File: rtl/imm_compress.sv
// imm_compress: packs a 32-bit value into a 16-bit immediate under an EOp code, with a 2-entry
// output FIFO and saturating stats. Optional macro AUTO_SEL_EN picks the first fitting EOp.
package imm_compress_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned EOP_W  = 2;

    typedef struct packed {
        logic [IMM_W-1:0] imm;
        logic [EOP_W-1:0] eop;
        logic             fit;
    } result_t;

endpackage

module imm_compress
    import imm_compress_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic [1:0]        in_eop,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_imm,
    output logic [1:0]        out_eop,
    output logic              out_fit,
    input  logic              stat_clr,
    output logic [CNT_W-1:0]  in_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } state_t;

    // Exact-representability test for one encoding.
    function automatic logic fits(input logic [DATA_W-1:0] d, input logic [EOP_W-1:0] eop);
        logic f;
        case (eop)
            2'b00:   f = (&d[31:15]) | ~(|d[31:15]);
            2'b01:   f = ~(|d[31:16]);
            2'b10:   f = ~(|d[15:0]);
            default: f = ~(|d[1:0]) & ((&d[31:17]) | ~(|d[31:17]));
        endcase
        return f;
    endfunction

    function automatic logic [IMM_W-1:0] imm_of(input logic [DATA_W-1:0] d,
                                               input logic [EOP_W-1:0] eop);
        logic [IMM_W-1:0] m;
        case (eop)
            2'b00, 2'b01: m = d[15:0];
            2'b10:        m = d[31:16];
            default:      m = d[17:2];
        endcase
        return m;
    endfunction

    state_t  state, state_nxt;
    result_t res_c;
    result_t head_q, tail_q;
    logic    accept_c, pop_c;
    logic    load_head_in_c, load_head_tail_c, load_tail_c;

`ifdef AUTO_SEL_EN
    logic unused_eop;
    assign unused_eop = ^in_eop;

    // Lowest-numbered fitting encoding wins; fall back to truncated sign form.
    always_comb begin
        res_c = '{imm: in_data[15:0], eop: 2'b00, fit: 1'b0};
        if (fits(in_data, 2'b00))
            res_c = '{imm: imm_of(in_data, 2'b00), eop: 2'b00, fit: 1'b1};
        else if (fits(in_data, 2'b01))
            res_c = '{imm: imm_of(in_data, 2'b01), eop: 2'b01, fit: 1'b1};
        else if (fits(in_data, 2'b10))
            res_c = '{imm: imm_of(in_data, 2'b10), eop: 2'b10, fit: 1'b1};
        else if (fits(in_data, 2'b11))
            res_c = '{imm: imm_of(in_data, 2'b11), eop: 2'b11, fit: 1'b1};
    end
`else
    always_comb begin
        res_c = '{imm: imm_of(in_data, in_eop), eop: in_eop, fit: fits(in_data, in_eop)};
    end
`endif

    assign accept_c = in_valid & in_ready;
    assign pop_c    = out_valid & out_ready;

    // FIFO control: head feeds out_*, tail holds the second entry when FULL.
    always_comb begin
        state_nxt        = state;
        load_head_in_c   = 1'b0;
        load_head_tail_c = 1'b0;
        load_tail_c      = 1'b0;
        case (state)
            EMPTY: begin
                if (accept_c) begin
                    state_nxt      = ONE;
                    load_head_in_c = 1'b1;
                end
            end
            ONE: begin
                if (accept_c && !pop_c) begin
                    state_nxt   = FULL;
                    load_tail_c = 1'b1;
                end else if (pop_c && !accept_c) begin
                    state_nxt = EMPTY;
                end else if (accept_c && pop_c) begin
                    load_head_in_c = 1'b1;
                end
            end
            FULL: begin
                if (pop_c) begin
                    state_nxt        = ONE;
                    load_head_tail_c = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt != FULL);
            out_valid <= (state_nxt != EMPTY);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            if (load_head_in_c)
                head_q <= res_c;
            else if (load_head_tail_c)
                head_q <= tail_q;
            if (load_tail_c)
                tail_q <= res_c;
        end
    end

    assign out_imm = head_q.imm;
    assign out_eop = head_q.eop;
    assign out_fit = head_q.fit;

    // Saturating statistics; clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_cnt   <= '0;
            miss_cnt <= '0;
        end else if (stat_clr) begin
            in_cnt   <= '0;
            miss_cnt <= '0;
        end else if (accept_c) begin
            if (in_cnt != {CNT_W{1'b1}})
                in_cnt <= in_cnt + CNT_W'(1);
            if (!res_c.fit && (miss_cnt != {CNT_W{1'b1}}))
                miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_compress.sv
// Self-checking bench for imm_compress; build with +define+AUTO_SEL_EN to cover auto selection.
module tb_imm_compress;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic [15:0] imm;
        logic [1:0]  eop;
        logic        fit;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic [1:0]       in_eop;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_imm;
    logic [1:0]       out_eop;
    logic             out_fit;
    logic             stat_clr;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] miss_cnt;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imm_compress #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_imm(out_imm), .out_eop(out_eop), .out_fit(out_fit),
        .stat_clr(stat_clr), .in_cnt(in_cnt), .miss_cnt(miss_cnt)
    );

    // Reference: rebuild the 32-bit value from the immediate and compare.
    function automatic logic [31:0] ext(input logic [15:0] imm, input logic [1:0] eop);
        case (eop)
            2'd0:    return {{16{imm[15]}}, imm};
            2'd1:    return {16'h0000, imm};
            2'd2:    return {imm, 16'h0000};
            default: return {{14{imm[15]}}, imm, 2'b00};
        endcase
    endfunction

    function automatic logic [15:0] pick(input logic [31:0] d, input logic [1:0] eop);
        logic [31:0] s;
        case (eop)
            2'd2:    s = d >> 16;
            2'd3:    s = d >> 2;
            default: s = d;
        endcase
        return s[15:0];
    endfunction

    function automatic exp_t model(input logic [31:0] d, input logic [1:0] eop);
        exp_t        e;
        logic [15:0] c;
`ifdef AUTO_SEL_EN
        e.imm = d[15:0];
        e.eop = 2'd0;
        e.fit = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            c = pick(d, 2'(k));
            if (ext(c, 2'(k)) == d) begin
                e.imm = c;
                e.eop = 2'(k);
                e.fit = 1'b1;
            end
        end
`else
        c     = pick(d, eop);
        e.imm = c;
        e.eop = eop;
        e.fit = (ext(c, eop) == d);
`endif
        return e;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (out_valid !== 1'b0 || {out_imm, out_eop, out_fit} !== 19'h0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b out=%h exp valid=0 out=0", out_valid, {out_imm, out_eop, out_fit});
        end
        checks++;
        if (in_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt: got in=%0d miss=%0d exp 0 0", in_cnt, miss_cnt);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b exp 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_encode();
        logic [31:0] vd[8];
        logic [1:0]  ve[8];
        exp_t        e;
        vd = '{32'hFFFF8006, 32'h00008006, 32'h00008006, 32'h80060000,
               32'hFFFE0018, 32'h00000019, 32'h80060001, 32'h00000000};
        ve = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd3};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vd[i];
            in_eop   = ve[i];
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL encode_ready[%0d]: got %b exp 1", i, in_ready);
            end
            sbq.push_back(model(vd[i], ve[i]));
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL encode_latency[%0d]: got valid=%b exp 1", i, out_valid);
            end else begin
                e = sbq.pop_front();
                checks++;
                if ({out_imm, out_eop, out_fit} !== e) begin
                    errors++;
                    $display("FAIL encode[%0d]: got imm=%h eop=%0d fit=%b exp imm=%h eop=%0d fit=%b",
                             i, out_imm, out_eop, out_fit, e.imm, e.eop, e.fit);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL encode_drain: got valid=%b exp 0", out_valid);
        end
        sbq.delete();
    endtask

`ifdef AUTO_SEL_EN
    task automatic test_auto_sel();
        logic [31:0] vd[3];
        exp_t        want[3];
        vd   = '{32'h00008006, 32'h80060000, 32'h12345678};
        want = '{'{16'h8006, 2'd1, 1'b1}, '{16'h8006, 2'd2, 1'b1}, '{16'h5678, 2'd0, 1'b0}};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = vd[i];
            in_eop   = 2'd3;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || {out_imm, out_eop, out_fit} !== want[i]) begin
                errors++;
                $display("FAIL auto_sel[%0d]: got valid=%b imm=%h eop=%0d fit=%b exp imm=%h eop=%0d fit=%b",
                         i, out_valid, out_imm, out_eop, out_fit, want[i].imm, want[i].eop, want[i].fit);
            end
        end
        @(negedge clk);
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] vd[3];
        logic [1:0]  ve[3];
        exp_t        e;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        vd = '{32'h00001111, 32'hFFFF9999, 32'h00050000};
        ve = '{2'd0, 2'd0, 2'd2};
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (out_valid !== 1'b1 || sbq.size() == 0 || {out_imm, out_eop, out_fit} !== sbq[0]) begin
                    errors++;
                    $display("FAIL bp_stable[%0d]: got valid=%b out=%h", c, out_valid, {out_imm, out_eop, out_fit});
                end
            end
            if (sent < 3) begin
                in_valid = 1'b1;
                in_data  = vd[sent];
                in_eop   = ve[sent];
                if (in_ready) begin
                    sbq.push_back(model(vd[sent], ve[sent]));
                    sent++;
                end
            end
        end
        checks++;
        if (sent != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepted: got accepted=%0d ready=%b exp 2 0", sent, in_ready);
        end
        while (got < 3 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            out_ready = 1'b1;
            if (out_valid) begin
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL bp_dup: got extra out=%h exp none", {out_imm, out_eop, out_fit});
                end else begin
                    e = sbq.pop_front();
                    if ({out_imm, out_eop, out_fit} !== e) begin
                        errors++;
                        $display("FAIL bp_order[%0d]: got %h exp %h", got, {out_imm, out_eop, out_fit}, e);
                    end
                end
                got++;
            end
            if (sent < 3) begin
                in_valid = 1'b1;
                in_data  = vd[sent];
                in_eop   = ve[sent];
                if (in_ready) begin
                    sbq.push_back(model(vd[sent], ve[sent]));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (got != 3 || sbq.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: got outputs=%0d left=%0d exp 3 0", got, sbq.size());
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_empty: got valid=%b exp 0", out_valid);
        end
        sbq.delete();
    endtask

    task automatic test_stats();
        logic [31:0] vd[5];
        exp_t        e;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        vd = '{32'h00001234, 32'h12345678, 32'hFFFF8006, 32'h7FFF0001, 32'h00000005};
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        checks++;
        if (in_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL stats_clr: got in=%0d miss=%0d exp 0 0", in_cnt, miss_cnt);
        end
        out_ready = 1'b1;
        while (got < 5 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                checks++;
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                if ({out_imm, out_eop, out_fit} !== e) begin
                    errors++;
                    $display("FAIL stats_out[%0d]: got %h exp %h", got, {out_imm, out_eop, out_fit}, e);
                end
                got++;
            end
            if (sent < 5) begin
                in_valid = 1'b1;
                in_data  = vd[sent];
                in_eop   = 2'd0;
                if (in_ready) begin
                    sbq.push_back(model(vd[sent], 2'd0));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (got != 5 || in_cnt !== CNT_W'(5) || miss_cnt !== CNT_W'(2)) begin
            errors++;
            $display("FAIL stats_count: got out=%0d in=%0d miss=%0d exp 5 5 2", got, in_cnt, miss_cnt);
        end
        sbq.delete();
    endtask

    task automatic test_stat_clr();
        exp_t e;
        out_ready = 1'b1;
        @(negedge clk);
        stat_clr = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_eop   = 2'd0;
        if (in_ready) sbq.push_back(model(32'h12345678, 2'd0));
        @(negedge clk);
        stat_clr = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (in_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL clr_priority: got in=%0d miss=%0d exp 0 0", in_cnt, miss_cnt);
        end
        checks++;
        e = (sbq.size() != 0) ? sbq.pop_front() : '1;
        if (out_valid !== 1'b1 || {out_imm, out_eop, out_fit} !== e) begin
            errors++;
            $display("FAIL clr_out: got valid=%b out=%h exp 1 %h", out_valid, {out_imm, out_eop, out_fit}, e);
        end
        @(negedge clk);
        sbq.delete();
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        exp_t        e;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        @(negedge clk);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr  = 1'b0;
        out_ready = 1'b1;
        while (got < 20 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                checks++;
                e = (sbq.size() != 0) ? sbq.pop_front() : '1;
                if ({out_imm, out_eop, out_fit} !== e) begin
                    errors++;
                    $display("FAIL sat_out[%0d]: got %h exp %h", got, {out_imm, out_eop, out_fit}, e);
                end
                got++;
            end
            if (sent < 20) begin
                d        = (sent % 3 == 0) ? 32'h12345678 : 32'(sent);
                in_valid = 1'b1;
                in_data  = d;
                in_eop   = 2'd0;
                if (in_ready) begin
                    sbq.push_back(model(d, 2'd0));
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (got != 20 || in_cnt !== CNT_W'(15) || miss_cnt !== CNT_W'(7)) begin
            errors++;
            $display("FAIL saturate: got out=%0d in=%0d miss=%0d exp 20 15 7", got, in_cnt, miss_cnt);
        end
        sbq.delete();
    endtask

    task automatic test_reset_full();
        exp_t e;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = (i < 2);
            in_data  = 32'h0000AAA0 + 32'(i);
            in_eop   = 2'd1;
        end
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_prefill: got ready=%b valid=%b exp 0 1", in_ready, out_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_cnt !== '0 || miss_cnt !== '0) begin
            errors++;
            $display("FAIL rst_async: got valid=%b in=%0d miss=%0d exp 0 0 0", out_valid, in_cnt, miss_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_release: got ready=%b valid=%b exp 1 0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h80060000;
        in_eop    = 2'd2;
        sbq.push_back(model(32'h80060000, 2'd2));
        @(negedge clk);
        in_valid = 1'b0;
        e = sbq.pop_front();
        checks++;
        if (out_valid !== 1'b1 || {out_imm, out_eop, out_fit} !== e) begin
            errors++;
            $display("FAIL rst_first: got valid=%b out=%h exp 1 %h", out_valid, {out_imm, out_eop, out_fit}, e);
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_eop    = '0;
        out_ready = 1'b0;
        stat_clr  = 1'b0;
        test_reset();
        test_encode();
`ifdef AUTO_SEL_EN
        test_auto_sel();
`endif
        test_back_to_back();
        test_stats();
        test_stat_clr();
        test_saturation();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
